uart_tx_buffered: RTL and testbench

- Serial UART transmitter that produces the asynchronous stream consumed by the `uart` receiver.
- Frame format: 8N1 or 8N2, LSB first, idle-high line.
- Accepts parallel bytes over a valid/ready handshake into a one-deep holding register, so back-to-back frames go out with no idle gap.
- Sits directly upstream of the receiver; in loopback benches `tx_stream` drives the receiver's `input_stream`.

---
 rtl/uart_tx_buffered.sv | 146 ++++++++++++++
 tb/tb_uart_tx_buffered.sv | 501 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1/8N2 UART transmitter. A one-deep holding register sits in front
// of the shifter so a producer can queue the next byte while a frame is on the
// line; that byte starts right after the current stop period with no idle gap.
module uart_tx_buffered #(
  parameter int unsigned CLKS_PER_BIT = 2605,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_stream,
  output logic       tx_busy,
  output logic       tx_done
);

  // Wide enough for the longest period timed, the whole stop period.
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT * STOP_BITS);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] StopLast = CntW'(CLKS_PER_BIT * STOP_BITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic            stream_q, stream_d;
  logic            done_q, done_d;
  logic            load;

  // State, counters, holding register and registered line/done outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      stream_q    <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      stream_q    <= stream_d;
      done_q      <= done_d;
    end
  end

  // Handshake capture, FSM sequencing and shifter load from the holding register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    done_d      = 1'b0;
    load        = 1'b0;

    // Acceptance needs an empty holder, so it never coincides with a load.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        load = hold_full_q;
      end
      StStart: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == StopLast) begin
          cnt_d  = '0;
          done_d = 1'b1;
          if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      cnt_d       = '0;
      state_d     = StStart;
    end
  end

  // Line level for the current state; registered so the output is glitch-free.
  always_comb begin
    stream_d = 1'b1;
    unique case (state_q)
      StStart: stream_d = 1'b0;
      StData:  stream_d = shift_q[idx_q];
      default: stream_d = 1'b1;
    endcase
  end

  assign tx_ready  = ~hold_full_q;
  assign tx_stream = stream_q;
  assign tx_done   = done_q;
  assign tx_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a line monitor decodes frames from the serial
// output and compares them against the queue of bytes the bench handed over.
module tb_uart_tx_buffered;

  localparam int C1    = 7;
  localparam int S1    = 1;
  localparam int Flen1 = (9 + S1) * C1;
  localparam int C2    = 4;
  localparam int S2    = 2;
  localparam int Flen2 = (9 + S2) * C2;

  typedef struct {
    logic [7:0] data;
    bit         shape_ok;
    int         start_cyc;
    int         done_cnt;
    int         done_cyc;
  } frame_t;

  logic       clock = 1'b0;
  logic       reset_n;
  int         cyc = 0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_stream, tx_busy, tx_done;
  logic [7:0] d2_data;
  logic       d2_valid;
  logic       d2_ready, d2_stream, d2_busy, d2_done;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         stray_done = 0;
  logic [7:0] exp_q[$];
  frame_t     obs_q[$];

  uart_tx_buffered #(.CLKS_PER_BIT(C1), .STOP_BITS(S1)) u_dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_stream(tx_stream),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  uart_tx_buffered #(.CLKS_PER_BIT(C2), .STOP_BITS(S2)) u_dut2 (
    .clock    (clock),
    .reset_n  (reset_n),
    .tx_data  (d2_data),
    .tx_valid (d2_valid),
    .tx_ready (d2_ready),
    .tx_stream(d2_stream),
    .tx_busy  (d2_busy),
    .tx_done  (d2_done)
  );

  // cyc is bumped right at each rising edge, so it names the cycle that edge opens.
  initial begin
    forever begin
      #5 clock = 1'b1;
      cyc++;
      #5 clock = 1'b0;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Line monitor: one slot per bit, each bit must hold one level for C1 cycles.
  logic [9:0] mon_bits;
  int         mon_k;
  int         mon_b;
  bit         mon_in = 1'b0;
  frame_t     mon_cur;
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n !== 1'b1) begin
        mon_in = 1'b0;
      end else begin
        if (!mon_in) begin
          if (tx_done === 1'b1) stray_done++;
          if (tx_stream === 1'b0) begin
            mon_in            = 1'b1;
            mon_k             = 0;
            mon_cur.start_cyc = cyc;
            mon_cur.shape_ok  = 1'b1;
            mon_cur.done_cnt  = 0;
            mon_cur.done_cyc  = -1;
          end
        end
        if (mon_in) begin
          mon_b = mon_k / C1;
          if (mon_k % C1 == 0) mon_bits[mon_b] = tx_stream;
          else if (tx_stream !== mon_bits[mon_b]) mon_cur.shape_ok = 1'b0;
          if (tx_done === 1'b1) begin
            mon_cur.done_cnt++;
            mon_cur.done_cyc = cyc;
          end
          mon_k++;
          if (mon_k == Flen1) begin
            mon_cur.data = mon_bits[8:1];
            if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) mon_cur.shape_ok = 1'b0;
            obs_q.push_back(mon_cur);
            mon_in = 1'b0;
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int acc);
    bit rdy;
    bit got;
    got = 1'b0;
    acc = -1;
    @(negedge clock);
    tx_data  = b;
    tx_valid = 1'b1;
    for (int t = 0; t < 4 * Flen1 && !got; t++) begin
      if (t != 0) @(negedge clock);
      rdy = tx_ready;
      @(posedge clock);
      if (rdy) begin
        got = 1'b1;
        acc = cyc;
      end
    end
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    if (got) begin
      exp_q.push_back(b);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: byte %h not accepted, tx_ready=%b, required 1", b, tx_ready);
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t;
    t = 0;
    while (obs_q.size() < n && t < budget) begin
      @(negedge clock);
      t++;
    end
    if (obs_q.size() < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout: saw %0d frames, required %0d", obs_q.size(), n);
    end
  endtask

  task automatic clear_scoreboard();
    repeat (2) @(negedge clock);
    obs_q.delete();
    exp_q.delete();
    stray_done = 0;
  endtask

  task automatic test_reset();
    int bad;
    reset_n  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    d2_valid = 1'b0;
    d2_data  = 8'h00;
    repeat (3) @(negedge clock);
    n_checks++;
    if (tx_stream !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stream: got %b, required 1", tx_stream);
    end
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, required 1", tx_ready);
    end
    n_checks++;
    if (tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_done: got busy=%b done=%b, required 0 0", tx_busy, tx_done);
    end
    n_checks++;
    if (d2_stream !== 1'b1 || d2_ready !== 1'b1 || d2_busy !== 1'b0 || d2_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dut2: got stream=%b ready=%b busy=%b done=%b, required 1 1 0 0",
               d2_stream, d2_ready, d2_busy, d2_done);
    end
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clock);
      tx_data = 8'($urandom);
      if (tx_stream !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_10000: %0d cycles left idle levels, required 0", bad);
    end
  endtask

  task automatic test_single();
    int     acc;
    frame_t f;
    clear_scoreboard();
    send_byte(8'b1001_0011, acc);
    @(negedge clock);
    n_checks++;
    if (tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ready_low: got %b, required 0", tx_ready);
    end
    @(negedge clock);
    n_checks++;
    if (tx_ready !== 1'b1 || tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready_busy: got ready=%b busy=%b, required 1 1", tx_ready, tx_busy);
    end
    wait_frames(1, 3 * Flen1);
    if (obs_q.size() >= 1) begin
      f = obs_q[0];
      n_checks++;
      if (f.data !== 8'b1001_0011 || !f.shape_ok) begin
        n_fail++;
        $display("FAIL single_data: got %b shape_ok=%0d, required 10010011 shape_ok=1",
                 f.data, f.shape_ok);
      end
      n_checks++;
      if (f.start_cyc - acc != 2) begin
        n_fail++;
        $display("FAIL single_latency: got %0d edges, required 2", f.start_cyc - acc);
      end
      n_checks++;
      if (f.done_cnt != 1 || f.done_cyc != f.start_cyc + Flen1 - 1) begin
        n_fail++;
        $display("FAIL single_done: got %0d pulses at offset %0d, required 1 at offset %0d",
                 f.done_cnt, f.done_cyc - f.start_cyc, Flen1 - 1);
      end
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if (tx_busy !== 1'b0 || tx_stream !== 1'b1 || stray_done != 0) begin
      n_fail++;
      $display("FAIL single_after: got busy=%b stream=%b stray_done=%0d, required 0 1 0",
               tx_busy, tx_stream, stray_done);
    end
  endtask

  task automatic test_back_to_back();
    int     acc1, acc2;
    frame_t f0, f1;
    clear_scoreboard();
    send_byte(8'hA5, acc1);
    send_byte(8'h3C, acc2);
    n_checks++;
    if (acc2 < 0 || acc2 >= acc1 + 2 + Flen1) begin
      n_fail++;
      $display("FAIL b2b_accept: second byte accepted at %0d, required before %0d",
               acc2, acc1 + 2 + Flen1);
    end
    wait_frames(2, 4 * Flen1);
    if (obs_q.size() >= 2) begin
      f0 = obs_q[0];
      f1 = obs_q[1];
      n_checks++;
      if (f0.data !== 8'hA5 || f1.data !== 8'h3C || !f0.shape_ok || !f1.shape_ok) begin
        n_fail++;
        $display("FAIL b2b_data: got %h %h, required a5 3c", f0.data, f1.data);
      end
      n_checks++;
      if (f1.start_cyc - f0.start_cyc != Flen1) begin
        n_fail++;
        $display("FAIL b2b_gap: got start spacing %0d, required %0d",
                 f1.start_cyc - f0.start_cyc, Flen1);
      end
      n_checks++;
      if (f0.done_cnt != 1 || f1.done_cnt != 1 || f1.done_cyc - f0.done_cyc != Flen1) begin
        n_fail++;
        $display("FAIL b2b_done: got pulses %0d/%0d spacing %0d, required 1/1 spacing %0d",
                 f0.done_cnt, f1.done_cnt, f1.done_cyc - f0.done_cyc, Flen1);
      end
    end
  endtask

  task automatic test_hold_ignore();
    int         acc;
    int         bad;
    int         rise;
    logic [7:0] want [3];
    want[0] = 8'h11;
    want[1] = 8'h22;
    want[2] = 8'h00;
    clear_scoreboard();
    send_byte(8'h11, acc);
    send_byte(8'h22, acc);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (tx_ready !== 1'b0) bad++;
    end
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_ready_low: ready high in %0d of 20 cycles, required 0", bad);
    end
    for (int t = 0; t < 4 * Flen1 && tx_ready !== 1'b1; t++) @(negedge clock);
    rise = cyc;
    send_byte(8'h00, acc);
    wait_frames(3, 4 * Flen1);
    repeat (Flen1) @(negedge clock);
    n_checks++;
    if (obs_q.size() != 3) begin
      n_fail++;
      $display("FAIL hold_count: got %0d frames, required 3", obs_q.size());
    end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== want[i] || !obs_q[i].shape_ok) begin
        n_fail++;
        $display("FAIL hold_data[%0d]: got %h, required %h", i, obs_q[i].data, want[i]);
      end
    end
    if (obs_q.size() >= 2) begin
      n_checks++;
      if (rise != obs_q[0].done_cyc) begin
        n_fail++;
        $display("FAIL hold_ready_rise: got cycle %0d, required %0d", rise, obs_q[0].done_cyc);
      end
    end
  endtask

  task automatic test_random();
    int acc;
    int gap;
    clear_scoreboard();
    for (int i = 0; i < 25; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 2 * Flen1));
      repeat (gap) @(negedge clock);
      send_byte(8'($urandom), acc);
    end
    wait_frames(exp_q.size(), 10 * Flen1);
    repeat (Flen1) @(negedge clock);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d frames, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].data !== exp_q[i] || !obs_q[i].shape_ok || obs_q[i].done_cnt != 1 ||
          obs_q[i].done_cyc != obs_q[i].start_cyc + Flen1 - 1) begin
        n_fail++;
        $display("FAIL rand_frame[%0d]: got %h shape=%0d done=%0d, required %h shape=1 done=1",
                 i, obs_q[i].data, obs_q[i].shape_ok, obs_q[i].done_cnt, exp_q[i]);
      end
    end
    n_checks++;
    if (stray_done != 0) begin
      n_fail++;
      $display("FAIL rand_stray_done: got %0d, required 0", stray_done);
    end
  endtask

  task automatic test_reset_mid();
    int   acc;
    int   bad;
    logic pre;
    clear_scoreboard();
    send_byte(8'h55, acc);
    send_byte(8'h66, bad);
    // Data bit 4 occupies frame slot 5, which starts 2 + 5*C1 cycles after acceptance.
    while (cyc < acc + 2 + 5 * C1 + 3) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (tx_stream !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: got stream=%b ready=%b busy=%b done=%b, required 1 1 0 0",
               tx_stream, tx_ready, tx_busy, tx_done);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 3 * Flen1; i++) begin
      @(negedge clock);
      if (tx_stream !== 1'b1 || tx_done !== 1'b0 || tx_ready !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0 || obs_q.size() != 0 || stray_done != 0) begin
      n_fail++;
      $display("FAIL midreset_idle: bad=%0d frames=%0d stray_done=%0d, required 0 0 0",
               bad, obs_q.size(), stray_done);
    end
    // Reset while the line is low in the start bit.
    clear_scoreboard();
    send_byte(8'h00, acc);
    while (cyc < acc + 4) @(posedge clock);
    #1;
    pre = tx_stream;
    n_checks++;
    if (pre !== 1'b0) begin
      n_fail++;
      $display("FAIL startbit_level: got %b, required 0", pre);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (tx_stream !== 1'b1) begin
      n_fail++;
      $display("FAIL startbit_reset: got %b, required 1", tx_stream);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2 * Flen1) @(negedge clock);
    n_checks++;
    if (obs_q.size() != 0 || tx_stream !== 1'b1 || tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL startbit_after: frames=%0d stream=%b ready=%b, required 0 1 1",
               obs_q.size(), tx_stream, tx_ready);
    end
  endtask

  task automatic test_two_stop();
    logic [7:0] b;
    logic       wave  [60];
    logic       dwave [60];
    logic       expv;
    int         k;
    int         bad;
    int         fall;
    int         dpos;
    b = 8'h81;
    @(negedge clock);
    n_checks++;
    if (d2_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL two_stop_ready: got %b, required 1", d2_ready);
    end
    d2_data  = b;
    d2_valid = 1'b1;
    @(posedge clock);
    #1;
    d2_valid = 1'b0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clock);
      wave[j]  = d2_stream;
      dwave[j] = d2_done;
    end
    bad  = 0;
    fall = -1;
    dpos = -1;
    for (int j = 0; j < 60; j++) begin
      k = j - 2;
      if (k < 0 || k >= Flen2) expv = 1'b1;
      else if (k / C2 == 0) expv = 1'b0;
      else if (k / C2 <= 8) expv = b[k / C2 - 1];
      else expv = 1'b1;
      if (wave[j] !== expv) bad++;
      if (fall < 0 && wave[j] === 1'b0) fall = j;
      if (dwave[j] === 1'b1) begin
        if (dpos >= 0 || j != 2 + Flen2 - 1) bad++;
        dpos = j;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL two_stop_wave: %0d cycles off the expected waveform, required 0", bad);
    end
    n_checks++;
    if (dpos - fall + 1 != Flen2) begin
      n_fail++;
      $display("FAIL two_stop_len: got %0d cycles, required %0d", dpos - fall + 1, Flen2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_ignore();
    test_random();
    test_reset_mid();
    test_two_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
